// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter sequencing requests onto one shared 8-bit logic ALU.
// Optional registered zero flag (rsp_zero) is enabled by defining ALU_ARB_ZERO_FLAG_EN.

module ALU (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] y
);

    always_comb begin
        unique case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = ~(a & b);
            default: y = ~(a | b);
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int unsigned START_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_data,
`ifdef ALU_ARB_ZERO_FLAG_EN
    output logic       rsp_zero,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic       prio;
    logic       gnt;
    logic       sel;
    logic       req_hs;
    logic       rsp_hs;
    logic [7:0] a_q, b_q, alu_y;
    logic [1:0] op_q;

    // Contention resolves to the priority pointer; a lone requester always wins.
    always_comb begin
        sel = req1_valid;
        if (req0_valid && req1_valid) begin
            sel = prio;
        end
    end

    assign req_hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_hs = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_hs) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && !sel;
        req1_ready = (state == IDLE) && req1_valid && sel;
        rsp0_valid = (state == RESP) && !gnt;
        rsp1_valid = (state == RESP) && gnt;
        busy       = (state != IDLE);
    end

    ALU u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= 1'(START_PRIO);
            gnt      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rsp_data <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
            rsp_zero <= 1'b1;
`endif
        end else begin
            if (state == IDLE && req_hs) begin
                gnt  <= sel;
                a_q  <= sel ? req1_a  : req0_a;
                b_q  <= sel ? req1_b  : req0_b;
                op_q <= sel ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                rsp_data <= alu_y;
`ifdef ALU_ARB_ZERO_FLAG_EN
                rsp_zero <= (alu_y == 8'h00);
`endif
            end
            if (state == RESP && rsp_hs) begin
                prio <= ~gnt;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: random and directed requests checked against a
// behavioural model of round-robin grant order, bitwise results and response timing.

module tb_alu_arbiter;

    localparam int unsigned START_PRIO = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic       rsp_zero;
`endif

    alu_arbiter #(.START_PRIO(START_PRIO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
`ifdef ALU_ARB_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         g;
        logic [7:0] d;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_t = 0;
    bit   in_flight = 0;
    bit   seen = 0;
    bit   post_rst = 0;
    bit   mprio = 1'(START_PRIO);

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // Monitor: predicts grants, pushes expected results, pops on response handshakes.
    always @(negedge clk) begin
        exp_t e;
        bit   g;
        if (rst) begin
            sbq.delete();
            in_flight = 0;
            seen      = 0;
            mprio     = 1'(START_PRIO);
            post_rst  = 1;
        end else begin
            if (post_rst) begin
                chk("reset_rsp_data", 32'(rsp_data), 32'h00);
                chk("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                chk("reset_busy", 32'(busy), 32'd0);
`ifdef ALU_ARB_ZERO_FLAG_EN
                chk("reset_rsp_zero", 32'(rsp_zero), 32'd1);
`endif
                post_rst = 0;
            end
            chk("busy", 32'(busy), 32'(in_flight));
            if (in_flight) begin
                chk("ready_low_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
            end else if (req0_valid || req1_valid) begin
                g = (req0_valid && req1_valid) ? mprio : req1_valid;
                chk("grant", {30'd0, req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
                e.g = g;
                e.d = g ? model(req1_a, req1_b, req1_op) : model(req0_a, req0_b, req0_op);
                sbq.push_back(e);
                in_flight = 1;
                hs_t      = cyc + 1;
                mprio     = ~g;
            end
            if (rsp0_valid || rsp1_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                end else begin
                    e = sbq[0];
                    chk("rsp_channel", {30'd0, rsp1_valid, rsp0_valid}, e.g ? 32'd2 : 32'd1);
                    chk("rsp_data", 32'(rsp_data), 32'(e.d));
`ifdef ALU_ARB_ZERO_FLAG_EN
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.d == 8'h00));
`endif
                    // Visible after edge T+1, i.e. sampled by the requester at T+2.
                    if (!seen) begin
                        chk("rsp_latency", 32'(cyc), 32'(hs_t + 1));
                        seen = 1;
                    end
                    if ((e.g && rsp1_ready) || (!e.g && rsp0_ready)) begin
                        void'(sbq.pop_front());
                        in_flight = 0;
                        seen      = 0;
                    end
                end
            end else if (in_flight && cyc > hs_t + 1) begin
                chk("missing_rsp", 32'(cyc), 32'(hs_t + 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input bit r, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit acc = 0;
        if (r) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = r ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        if (!acc) chk("issue_timeout", 32'd0, 32'd1);
        step();
        if (r) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit r);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = r ? rsp1_valid : rsp0_valid;
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        bit acc0, acc1;
        bit done;
        do_reset();

        // Single requester, all four opcodes.
        for (int unsigned op = 0; op < 4; op++) begin
            issue(0, 8'hF0, 8'h3C, 2'(op));
        end
        repeat (4) step();

        // Continuous contention from reset priority.
        do_reset();
        req0_a = 8'hAA; req0_b = 8'h55; req0_op = 2'b01; req0_valid = 1'b1;
        req1_a = 8'hAA; req1_b = 8'h55; req1_op = 2'b11; req1_valid = 1'b1;
        repeat (30) step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) step();

        // Response backpressure on requester 1, requester 0 waiting.
        rsp1_ready = 1'b0;
        issue(1, 8'h33, 8'h0F, 2'b10);
        req0_a = 8'h12; req0_b = 8'h34; req0_op = 2'b00; req0_valid = 1'b1;
        wait_rsp(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp1_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'hFC);
            chk("bp_busy", 32'(busy), 32'd1);
            step();
        end
        rsp1_ready = 1'b1;
        issue(0, 8'h12, 8'h34, 2'b00);
        repeat (5) step();

        // Reset while holding a response.
        rsp0_ready = 1'b0;
        issue(0, 8'h5A, 8'hC3, 2'b01);
        wait_rsp(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        repeat (8) step();

        // Reset coinciding with a request handshake.
        req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 2'b00; req0_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        repeat (6) step();

        // Requester 1 withdraws valid while the arbiter is busy.
        rsp0_ready = 1'b0;
        issue(0, 8'h81, 8'h18, 2'b11);
        req1_a = 8'h77; req1_b = 8'h11; req1_op = 2'b01; req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        repeat (3) step();
        rsp0_ready = 1'b1;
        repeat (10) step();

        // Zero-result and non-zero-result patterns.
        issue(0, 8'h0F, 8'hF0, 2'b00);
        issue(0, 8'h0F, 8'hF0, 2'b01);
        repeat (4) step();

        // Randomised traffic with random response backpressure and withdrawals.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
            if (!req0_valid || acc0) begin
                req0_valid = $urandom_range(0, 1);
                req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || acc1) begin
                req1_valid = $urandom_range(0, 1);
                req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = (sbq.size() == 0) && !in_flight;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
